// File: rtl/bc_control_unit_if.sv
// Datapath-facing bundle for bc_control_unit: status words in, bus select and control vector out.
interface bc_control_unit_if #(
    parameter int WIDTH      = 16,
    parameter int CTRL_LNGTH = 20
);
    logic [WIDTH-1:0]      IR_IN;
    logic [WIDTH-1:0]      AC_IN;
    logic [WIDTH-1:0]      DR_IN;
    logic [2:0]            BUS_SEL;
    logic [CTRL_LNGTH-1:0] CTRL_SGNLS;

    modport master (
        input  IR_IN,
        input  AC_IN,
        input  DR_IN,
        output BUS_SEL,
        output CTRL_SGNLS
    );

    modport slave (
        output IR_IN,
        output AC_IN,
        output DR_IN,
        input  BUS_SEL,
        input  CTRL_SGNLS
    );
endinterface

// File: rtl/bc_control_unit.sv
// Hardwired fetch/decode/execute control for the 16-bit basic computer.
// Optional BC_SINGLE_STEP_EN adds a STEP input and a PAUSE state after every instruction.
module bc_control_unit #(
    parameter int WIDTH      = 16,
    parameter int CTRL_LNGTH = 20
) (
    input  logic                    clk,
    input  logic                    RST,
    input  logic                    START,
`ifdef BC_SINGLE_STEP_EN
    input  logic                    STEP,
`endif
    bc_control_unit_if.master       dp,
    output logic [2:0]              SC_OUT,
    output logic                    INSTR_DONE,
    output logic                    HALTED
);

    localparam int LD_AR   = 0;
    localparam int INR_AR  = 1;
    localparam int LD_PC   = 3;
    localparam int INR_PC  = 4;
    localparam int LD_DR   = 6;
    localparam int INR_DR  = 7;
    localparam int LD_AC   = 9;
    localparam int INR_AC  = 10;
    localparam int CLR_AC  = 11;
    localparam int LD_IR   = 12;
    localparam int MEM_WE  = 16;
    localparam int ALU_LSB = 17;

    localparam logic [2:0] BUS_AR  = 3'd0;
    localparam logic [2:0] BUS_PC  = 3'd1;
    localparam logic [2:0] BUS_DR  = 3'd2;
    localparam logic [2:0] BUS_AC  = 3'd3;
    localparam logic [2:0] BUS_IR  = 3'd4;
    localparam logic [2:0] BUS_MEM = 3'd6;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_AND  = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_CMA  = 3'b011;

`ifdef BC_SINGLE_STEP_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_PAUSE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
`endif

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_sc;
    logic [2:0]            w_sc_nxt;
    logic                  r_i;
    logic [2:0]            r_d;
    logic                  w_latch;
    logic                  w_done;
    logic                  w_halt;
    logic [2:0]            w_bus;
    logic [CTRL_LNGTH-1:0] w_ctrl;
    logic                  w_ac_zero;
    logic                  w_ac_neg;
    logic                  w_dr_zero;
    logic                  w_unused_ir;

    assign w_ac_zero   = (dp.AC_IN == '0);
    assign w_ac_neg    = dp.AC_IN[WIDTH-1];
    assign w_dr_zero   = (dp.DR_IN == '0);
    assign w_unused_ir = ^{dp.IR_IN[10], dp.IR_IN[8:6], dp.IR_IN[1]};

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_sc    <= '0;
            r_i     <= 1'b0;
            r_d     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sc    <= w_sc_nxt;
            if (w_latch) begin
                r_i <= dp.IR_IN[15];
                r_d <= dp.IR_IN[14:12];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sc_nxt    = r_sc;
        w_bus       = '0;
        w_ctrl      = '0;
        w_done      = 1'b0;
        w_latch     = 1'b0;
        w_halt      = 1'b0;

        case (r_state)
            S_IDLE, S_HALT: begin
                w_sc_nxt = '0;
                if (START) begin
                    w_state_nxt = S_RUN;
                end
            end
`ifdef BC_SINGLE_STEP_EN
            S_PAUSE: begin
                w_sc_nxt = '0;
                if (STEP) begin
                    w_state_nxt = S_RUN;
                end
            end
`endif
            S_RUN: begin
                case (r_sc)
                    3'd0: begin
                        w_bus         = BUS_PC;
                        w_ctrl[LD_AR] = 1'b1;
                    end
                    3'd1: begin
                        w_bus          = BUS_MEM;
                        w_ctrl[LD_IR]  = 1'b1;
                        w_ctrl[INR_PC] = 1'b1;
                    end
                    3'd2: begin
                        w_bus         = BUS_IR;
                        w_ctrl[LD_AR] = 1'b1;
                        w_latch       = 1'b1;
                    end
                    3'd3: begin
                        if (r_d == 3'd7) begin
                            w_done = 1'b1;
                            // Register-reference priority: lowest set IR bit wins.
                            if (!r_i) begin
                                if (dp.IR_IN[0]) begin
                                    w_halt = 1'b1;
                                end else if (dp.IR_IN[2]) begin
                                    w_ctrl[INR_PC] = w_ac_zero;
                                end else if (dp.IR_IN[3]) begin
                                    w_ctrl[INR_PC] = w_ac_neg;
                                end else if (dp.IR_IN[4]) begin
                                    w_ctrl[INR_PC] = ~w_ac_neg;
                                end else if (dp.IR_IN[5]) begin
                                    w_ctrl[INR_AC] = 1'b1;
                                end else if (dp.IR_IN[9]) begin
                                    w_ctrl[LD_AC]            = 1'b1;
                                    w_ctrl[ALU_LSB +: 3]     = ALU_CMA;
                                end else if (dp.IR_IN[11]) begin
                                    w_ctrl[CLR_AC] = 1'b1;
                                end
                            end
                        end else if (r_i) begin
                            w_bus         = BUS_MEM;
                            w_ctrl[LD_AR] = 1'b1;
                        end
                    end
                    3'd4: begin
                        case (r_d)
                            3'd0, 3'd1, 3'd2, 3'd6: begin
                                w_bus         = BUS_MEM;
                                w_ctrl[LD_DR] = 1'b1;
                            end
                            3'd3: begin
                                w_bus          = BUS_AC;
                                w_ctrl[MEM_WE] = 1'b1;
                                w_done         = 1'b1;
                            end
                            3'd4: begin
                                w_bus         = BUS_AR;
                                w_ctrl[LD_PC] = 1'b1;
                                w_done        = 1'b1;
                            end
                            3'd5: begin
                                w_bus          = BUS_PC;
                                w_ctrl[MEM_WE] = 1'b1;
                                w_ctrl[INR_AR] = 1'b1;
                            end
                            default: w_done = 1'b1;
                        endcase
                    end
                    3'd5: begin
                        case (r_d)
                            3'd0: begin
                                w_ctrl[LD_AC]        = 1'b1;
                                w_ctrl[ALU_LSB +: 3] = ALU_AND;
                                w_done               = 1'b1;
                            end
                            3'd1: begin
                                w_ctrl[LD_AC]        = 1'b1;
                                w_ctrl[ALU_LSB +: 3] = ALU_ADD;
                                w_done               = 1'b1;
                            end
                            3'd2: begin
                                w_ctrl[LD_AC]        = 1'b1;
                                w_ctrl[ALU_LSB +: 3] = ALU_PASS;
                                w_done               = 1'b1;
                            end
                            3'd5: begin
                                w_bus         = BUS_AR;
                                w_ctrl[LD_PC] = 1'b1;
                                w_done        = 1'b1;
                            end
                            3'd6: w_ctrl[INR_DR] = 1'b1;
                            default: w_done = 1'b1;
                        endcase
                    end
                    3'd6: begin
                        if (r_d == 3'd6) begin
                            w_bus          = BUS_DR;
                            w_ctrl[MEM_WE] = 1'b1;
                            w_ctrl[INR_PC] = w_dr_zero;
                        end
                        w_done = 1'b1;
                    end
                    default: w_done = 1'b1;
                endcase

                w_sc_nxt = w_done ? 3'd0 : r_sc + 3'd1;
                if (w_halt) begin
                    w_state_nxt = S_HALT;
`ifdef BC_SINGLE_STEP_EN
                end else if (w_done) begin
                    w_state_nxt = S_PAUSE;
`endif
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_sc_nxt    = '0;
            end
        endcase
    end

    assign dp.BUS_SEL    = w_bus;
    assign dp.CTRL_SGNLS = w_ctrl;
    assign SC_OUT        = (r_state == S_RUN) ? r_sc : 3'd0;
    assign INSTR_DONE    = w_done;
    assign HALTED        = (r_state == S_HALT);

endmodule

// File: tb/tb_bc_control_unit.sv
// Directed bench for bc_control_unit: per-cycle expected outputs queued then checked mid-cycle.
module tb_bc_control_unit;

    localparam logic [19:0] C_LD_AR   = 20'h00001;
    localparam logic [19:0] C_INR_AR  = 20'h00002;
    localparam logic [19:0] C_LD_PC   = 20'h00008;
    localparam logic [19:0] C_INR_PC  = 20'h00010;
    localparam logic [19:0] C_LD_DR   = 20'h00040;
    localparam logic [19:0] C_INR_DR  = 20'h00080;
    localparam logic [19:0] C_LD_AC   = 20'h00200;
    localparam logic [19:0] C_INR_AC  = 20'h00400;
    localparam logic [19:0] C_CLR_AC  = 20'h00800;
    localparam logic [19:0] C_LD_IR   = 20'h01000;
    localparam logic [19:0] C_MEM_WE  = 20'h10000;
    localparam logic [19:0] C_ALU_AND = 20'h20000;
    localparam logic [19:0] C_ALU_ADD = 20'h40000;
    localparam logic [19:0] C_ALU_CMA = 20'h60000;

    typedef struct {
        string       tag;
        logic [2:0]  bs;
        logic [19:0] cs;
        logic [2:0]  sc;
        logic        dn;
        logic        hl;
    } exp_t;

    logic       clk;
    logic       RST;
    logic       START;
    logic       STEP;
    logic [2:0] SC_OUT;
    logic       INSTR_DONE;
    logic       HALTED;
    int         total;
    int         bad;
    exp_t       sbq[$];

    bc_control_unit_if #(.WIDTH(16), .CTRL_LNGTH(20)) dp_if ();

    bc_control_unit #(.WIDTH(16), .CTRL_LNGTH(20)) dut (
        .clk        (clk),
        .RST        (RST),
        .START      (START),
`ifdef BC_SINGLE_STEP_EN
        .STEP       (STEP),
`endif
        .dp         (dp_if.master),
        .SC_OUT     (SC_OUT),
        .INSTR_DONE (INSTR_DONE),
        .HALTED     (HALTED)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue the expectation, compare at the falling edge, then move to just after the next rising edge.
    task automatic cyc(input string tag, input logic [2:0] bs, input logic [19:0] cs,
                       input logic [2:0] sc, input logic dn, input logic hl);
        exp_t e;
        e.tag = tag; e.bs = bs; e.cs = cs; e.sc = sc; e.dn = dn; e.hl = hl;
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        total++;
        assert (dp_if.BUS_SEL === e.bs) else begin
            bad++;
            $error("FAIL %s bus_sel got=%0h exp=%0h", e.tag, dp_if.BUS_SEL, e.bs);
        end
        total++;
        assert (dp_if.CTRL_SGNLS === e.cs) else begin
            bad++;
            $error("FAIL %s ctrl got=%05h exp=%05h", e.tag, dp_if.CTRL_SGNLS, e.cs);
        end
        total++;
        assert (SC_OUT === e.sc) else begin
            bad++;
            $error("FAIL %s sc got=%0d exp=%0d", e.tag, SC_OUT, e.sc);
        end
        total++;
        assert (INSTR_DONE === e.dn) else begin
            bad++;
            $error("FAIL %s done got=%b exp=%b", e.tag, INSTR_DONE, e.dn);
        end
        total++;
        assert (HALTED === e.hl) else begin
            bad++;
            $error("FAIL %s halted got=%b exp=%b", e.tag, HALTED, e.hl);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [15:0] ir);
        cyc({tag, "_t0"}, 3'd1, C_LD_AR, 3'd0, 1'b0, 1'b0);
        cyc({tag, "_t1"}, 3'd6, C_LD_IR | C_INR_PC, 3'd1, 1'b0, 1'b0);
        dp_if.IR_IN = ir;
        cyc({tag, "_t2"}, 3'd4, C_LD_AR, 3'd2, 1'b0, 1'b0);
    endtask

    task automatic resume();
`ifdef BC_SINGLE_STEP_EN
        cyc("pause", 3'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        STEP = 1'b1;
        cyc("pause_step", 3'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        STEP = 1'b0;
`endif
    endtask

    task automatic regref(input string tag, input logic [15:0] ir, input logic [19:0] cs);
        fetch(tag, ir);
        cyc({tag, "_t3"}, 3'd0, cs, 3'd3, 1'b1, 1'b0);
        resume();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST   = 1'b1;
        START = 1'b0;
        STEP  = 1'b0;
        dp_if.IR_IN = '0;
        dp_if.AC_IN = '0;
        dp_if.DR_IN = '0;
        repeat (2) @(posedge clk);
        #1;
        RST = 1'b0;

        for (int k = 0; k < 10; k++) cyc("idle", 3'd0, 20'h0, 3'd0, 1'b0, 1'b0);

        // ADD direct; a START pulse mid-instruction must be ignored
        START = 1'b1;
        cyc("start_idle", 3'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        START = 1'b0;
        fetch("add", 16'h1123);
        START = 1'b1;
        cyc("add_t3", 3'd0, 20'h0, 3'd3, 1'b0, 1'b0);
        START = 1'b0;
        cyc("add_t4", 3'd6, C_LD_DR, 3'd4, 1'b0, 1'b0);
        cyc("add_t5", 3'd0, C_LD_AC | C_ALU_ADD, 3'd5, 1'b1, 1'b0);
        resume();

        fetch("bsa", 16'hD050);
        cyc("bsa_t3", 3'd6, C_LD_AR, 3'd3, 1'b0, 1'b0);
        cyc("bsa_t4", 3'd1, C_MEM_WE | C_INR_AR, 3'd4, 1'b0, 1'b0);
        cyc("bsa_t5", 3'd0, C_LD_PC, 3'd5, 1'b1, 1'b0);
        resume();

        fetch("and", 16'h0000);
        cyc("and_t3", 3'd0, 20'h0, 3'd3, 1'b0, 1'b0);
        cyc("and_t4", 3'd6, C_LD_DR, 3'd4, 1'b0, 1'b0);
        cyc("and_t5", 3'd0, C_LD_AC | C_ALU_AND, 3'd5, 1'b1, 1'b0);
        resume();

        fetch("lda", 16'h2000);
        cyc("lda_t3", 3'd0, 20'h0, 3'd3, 1'b0, 1'b0);
        cyc("lda_t4", 3'd6, C_LD_DR, 3'd4, 1'b0, 1'b0);
        cyc("lda_t5", 3'd0, C_LD_AC, 3'd5, 1'b1, 1'b0);
        resume();

        fetch("sta", 16'h3000);
        cyc("sta_t3", 3'd0, 20'h0, 3'd3, 1'b0, 1'b0);
        cyc("sta_t4", 3'd3, C_MEM_WE, 3'd4, 1'b1, 1'b0);
        resume();

        fetch("bun", 16'hC123);
        cyc("bun_t3", 3'd6, C_LD_AR, 3'd3, 1'b0, 1'b0);
        cyc("bun_t4", 3'd0, C_LD_PC, 3'd4, 1'b1, 1'b0);
        resume();

        fetch("isz0", 16'h6010);
        cyc("isz0_t3", 3'd0, 20'h0, 3'd3, 1'b0, 1'b0);
        cyc("isz0_t4", 3'd6, C_LD_DR, 3'd4, 1'b0, 1'b0);
        cyc("isz0_t5", 3'd0, C_INR_DR, 3'd5, 1'b0, 1'b0);
        dp_if.DR_IN = 16'h0000;
        cyc("isz0_t6", 3'd2, C_MEM_WE | C_INR_PC, 3'd6, 1'b1, 1'b0);
        resume();

        fetch("isz5", 16'h6010);
        cyc("isz5_t3", 3'd0, 20'h0, 3'd3, 1'b0, 1'b0);
        cyc("isz5_t4", 3'd6, C_LD_DR, 3'd4, 1'b0, 1'b0);
        cyc("isz5_t5", 3'd0, C_INR_DR, 3'd5, 1'b0, 1'b0);
        dp_if.DR_IN = 16'h0005;
        cyc("isz5_t6", 3'd2, C_MEM_WE, 3'd6, 1'b1, 1'b0);
        resume();

        dp_if.AC_IN = 16'h0000;
        regref("sza_z", 16'h7004, C_INR_PC);
        regref("spa_z", 16'h7010, C_INR_PC);
        dp_if.AC_IN = 16'h8000;
        regref("sza_nz", 16'h7004, 20'h0);
        regref("spa_n", 16'h7010, 20'h0);
        regref("sna_n", 16'h7008, C_INR_PC);
        regref("multi", 16'h7A20, C_INR_AC);
        regref("cma", 16'h7200, C_LD_AC | C_ALU_CMA);
        regref("cla", 16'h7800, C_CLR_AC);
        regref("nop", 16'h7100, 20'h0);
        regref("io", 16'hF800, 20'h0);

        // HLT together with SZA (AC=0): HLT has priority
        dp_if.AC_IN = 16'h0000;
        fetch("hlt", 16'h7005);
        cyc("hlt_t3", 3'd0, 20'h0, 3'd3, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cyc("halt", 3'd0, 20'h0, 3'd0, 1'b0, 1'b1);
        START = 1'b1;
        cyc("halt_start", 3'd0, 20'h0, 3'd0, 1'b0, 1'b1);
        START = 1'b0;

        // Restart at T0, then abort ISZ at T5 by reset (START with RST ignored)
        fetch("iszr", 16'h6010);
        cyc("iszr_t3", 3'd0, 20'h0, 3'd3, 1'b0, 1'b0);
        cyc("iszr_t4", 3'd6, C_LD_DR, 3'd4, 1'b0, 1'b0);
        RST = 1'b1;
        cyc("iszr_t5", 3'd0, C_INR_DR, 3'd5, 1'b0, 1'b0);
        START = 1'b1;
        cyc("rst_abort", 3'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        RST   = 1'b0;
        START = 1'b0;
        for (int k = 0; k < 3; k++) cyc("post_rst_idle", 3'd0, 20'h0, 3'd0, 1'b0, 1'b0);

`ifdef BC_SINGLE_STEP_EN
        START = 1'b1;
        cyc("ss_start", 3'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        START = 1'b0;
        fetch("ss_sta", 16'h3000);
        cyc("ss_sta_t3", 3'd0, 20'h0, 3'd3, 1'b0, 1'b0);
        cyc("ss_sta_t4", 3'd3, C_MEM_WE, 3'd4, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cyc("ss_pause", 3'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        START = 1'b1;
        cyc("ss_pause_start", 3'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        START = 1'b0;
        cyc("ss_pause_hold", 3'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        STEP = 1'b1;
        cyc("ss_step", 3'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        STEP = 1'b0;
        cyc("ss_t0", 3'd1, C_LD_AR, 3'd0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
